// File: rtl/freq_counter_multi.sv
// Multi-channel frequency counter: counts synchronised rising edges per channel over a
// GATE_CYCLES-long window, publishing saturated counts and overflow flags with a one-cycle valid.
module freq_counter_multi #(
  parameter int NCH         = 4,
  parameter int CNT_W       = 16,
  parameter int GATE_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       sig_in,
  input  logic                 mode,
  input  logic                 start,
  output logic                 busy,
  output logic                 valid,
  output logic [NCH*CNT_W-1:0] count,
  output logic [NCH-1:0]       ovf
);

  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic {IDLE, GATE} state_t;

  state_t                      state, state_nxt;
  logic [GW-1:0]               gate_cnt, gate_cnt_nxt;
  logic                        publish;
  logic [NCH-1:0]              sync1, sync2, hist, edge_det;
  logic [NCH-1:0][CNT_W-1:0]   acc, acc_inc;
  logic [NCH-1:0]              sticky, sticky_inc;

  // Synchroniser and history run in every state so IDLE edges are consumed, not deferred.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign edge_det = sync2 & ~hist;

  always_comb begin
    acc_inc    = acc;
    sticky_inc = sticky;
    for (int i = 0; i < NCH; i++) begin
      if (edge_det[i]) begin
        if (acc[i] == CMAX) sticky_inc[i] = 1'b1;
        else                acc_inc[i]    = acc[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gate_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gate_cnt <= gate_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    gate_cnt_nxt = gate_cnt;
    publish      = 1'b0;
    case (state)
      IDLE: begin
        gate_cnt_nxt = '0;
        if (!mode || start) state_nxt = GATE;
      end
      GATE: begin
        if (gate_cnt == LAST) begin
          publish      = 1'b1;
          gate_cnt_nxt = '0;
          if (mode) state_nxt = IDLE;
        end else begin
          gate_cnt_nxt = gate_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The last gate cycle's edge is folded into the published value, then the window restarts clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      sticky <= '0;
    end else if (state == GATE) begin
      if (publish) begin
        acc    <= '0;
        sticky <= '0;
      end else begin
        acc    <= acc_inc;
        sticky <= sticky_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      count <= '0;
      ovf   <= '0;
    end else begin
      valid <= publish;
      if (publish) begin
        count <= acc_inc;
        ovf   <= sticky_inc;
      end
    end
  end

  assign busy = (state == GATE);

endmodule

// File: doc/freq_counter_multi.md
FREQ_COUNTER_MULTI -- requirements
Module: freq_counter_multi

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent measurement channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16: width of each per-channel edge count.
REQ-003 SHALL have parameter GATE_CYCLES, default 1000: gate window length in clk cycles (>= 2).
REQ-004 SHALL have port clk  input  1: single reference clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port sig_in  input  NCH: measured signals, asynchronous to clk.
REQ-007 SHALL have port mode  input  1: 0 = continuous windows, 1 = single-shot.
REQ-008 SHALL have port start  input  1: single-shot trigger, sampled in IDLE only.
REQ-009 SHALL have port busy  output  1: high while a gate window is open.
REQ-010 SHALL have port valid  output  1: one-cycle pulse when new counts are published.
REQ-011 SHALL have port count  output  NCH*CNT_W: published counts, channel i at bits [i*CNT_W +: CNT_W].
REQ-012 SHALL have port ovf  output  NCH: per-channel saturation flag for the published window.

Function
REQ-013 SHALL pass each sig_in bit through a 2-flop synchroniser, then a history flop; a rising edge SHALL be detected when sync output = 1 and history = 0.
REQ-014 SHALL count only rising edges, one per detected edge; a sig_in level change needs at least 2 clk of stable level to be counted.
REQ-015 SHALL implement FSM states IDLE and GATE; busy = 1 exactly in GATE.
REQ-016 IDLE -> GATE SHALL occur on the cycle after entering IDLE when mode = 0, or when mode = 1 and start = 1.
REQ-017 In GATE, a gate counter SHALL run 0..GATE_CYCLES-1; detected edges in all GATE_CYCLES cycles SHALL be accumulated, including the last.
REQ-018 On the last gate cycle, final accumulator values (including that cycle's edge) SHALL load into count/ovf on the next clk edge, valid SHALL pulse high for that one cycle, and accumulators SHALL clear.
REQ-019 At window end, mode = 0 SHALL start the next window on the immediately following cycle (no dead cycle, no lost edges); mode = 1 SHALL return to IDLE.
REQ-020 mode SHALL be sampled only at window end or in IDLE; mid-window changes SHALL NOT affect the current window.
REQ-021 start in GATE SHALL be ignored; start held high in IDLE with mode = 1 SHALL retrigger after each window.
REQ-022 Accumulators SHALL saturate at 2^CNT_W-1; further edges SHALL set that channel's sticky overflow bit, published to ovf and cleared with the accumulator.
REQ-023 Edges detected in IDLE SHALL NOT be counted; synchroniser/history flops SHALL run in all states.
REQ-024 count and ovf SHALL hold their last published values until the next publish.
REQ-025 Channels SHALL be fully independent; activity on one SHALL NOT alter another's count.

Reset
REQ-026 reset = 1 SHALL force state IDLE, gate counter 0, all accumulators, sticky bits, synchroniser and history flops 0, and outputs busy = 0, valid = 0, count = 0, ovf = 0 on the next clk edge.
REQ-027 reset asserted mid-window SHALL discard the window with no valid pulse; reset has priority over publish on the same cycle.
REQ-028 After reset deasserts, mode = 0 SHALL start the first window on the cycle after the first IDLE cycle.

Verification (NCH=2, CNT_W=8, GATE_CYCLES=100 unless stated)
REQ-029 Single-shot: mode=1, start 1-cycle pulse, sig_in[0] period 10 clk (5 high/5 low) -> busy for 100 cycles, one valid, count[7:0]=10, ovf[0]=0, then busy=0.
REQ-030 Saturation: CNT_W=4, sig_in[0] period 2 clk -> count[3:0]=15, ovf[0]=1; next window with sig_in[0] static -> count[3:0]=0, ovf[0]=0.
REQ-031 Continuous: mode=0, sig_in[1] period 4 clk -> valid every 100 cycles exactly, busy constantly 1, count[15:8]=25 each window.
REQ-032 Reset mid-window: reset for 1 cycle at gate cycle 50 -> no valid, count=0, busy=0 in the cycle after reset.
REQ-033 Ignored start: start pulses at gate cycles 10 and 99 in single-shot -> exactly one valid, then IDLE.
REQ-034 Independence: sig_in[0] period 10, sig_in[1] held 1 -> count[7:0]=10, count[15:8]=0.
